// File: rtl/ss_feeder.sv
// Byte-serial frame loader for SS: assembles 16-bit words into a local buffer, replays them as one
// gap-free in_valid burst, then holds off for the SS compute time before accepting the next header.
module ss_feeder (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        s_valid,
   input  logic [7:0]  s_data,
   output logic        s_ready,
   output logic        ss_in_valid,
   output logic [15:0] ss_matrix,
   output logic        ss_matrix_size,
   output logic        busy
);

   typedef enum logic [1:0] {HDR, LOAD, PLAY, GAP} state_t;

   state_t      state, state_nxt;
   logic [5:0]  cnt, cnt_nxt;
   logic        phase, phase_nxt;
   logic        size, size_nxt;
   logic [7:0]  hold, hold_nxt;
   logic        ready_nxt;
   logic        wr_en;
   logic        xfer;
   logic [5:0]  last_word;
   logic [5:0]  last_gap;
   logic [15:0] mem [32];

   assign xfer      = s_valid && s_ready;
   assign last_word = size ? 6'd31 : 6'd7;
   // GAP length matches the SS compute duration for the latched size
   assign last_gap  = size ? 6'd10 : 6'd4;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= HDR;
         cnt     <= 6'd0;
         phase   <= 1'b0;
         size    <= 1'b0;
         hold    <= 8'd0;
         s_ready <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         phase   <= phase_nxt;
         size    <= size_nxt;
         hold    <= hold_nxt;
         s_ready <= ready_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      phase_nxt = phase;
      size_nxt  = size;
      hold_nxt  = hold;
      wr_en     = 1'b0;
      case (state)
         HDR: begin
            if (xfer) begin
               size_nxt  = s_data[0];
               cnt_nxt   = 6'd0;
               phase_nxt = 1'b0;
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            if (xfer) begin
               if (!phase) begin
                  hold_nxt  = s_data;
                  phase_nxt = 1'b1;
               end else begin
                  wr_en     = 1'b1;
                  phase_nxt = 1'b0;
                  if (cnt == last_word) begin
                     cnt_nxt   = 6'd0;
                     state_nxt = PLAY;
                  end else begin
                     cnt_nxt = cnt + 6'd1;
                  end
               end
            end
         end
         PLAY: begin
            if (cnt == last_word) begin
               cnt_nxt   = 6'd0;
               state_nxt = GAP;
            end else begin
               cnt_nxt = cnt + 6'd1;
            end
         end
         GAP: begin
            if (cnt == last_gap) begin
               cnt_nxt   = 6'd0;
               state_nxt = HDR;
            end else begin
               cnt_nxt = cnt + 6'd1;
            end
         end
         default: state_nxt = HDR;
      endcase
      // s_ready is registered so it stays low for the first cycle after reset release
      ready_nxt = (state_nxt == HDR) || (state_nxt == LOAD);
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[cnt[4:0]] <= {hold, s_data};
      end
   end

   always_comb begin
      ss_in_valid    = (state == PLAY);
      ss_matrix      = 16'd0;
      ss_matrix_size = 1'b0;
      busy           = (state != HDR);
      if (state == PLAY) begin
         ss_matrix      = mem[cnt[4:0]];
         ss_matrix_size = (cnt == 6'd0) ? size : 1'b0;
      end
   end

endmodule

// File: tb/tb_ss_feeder.sv
// Directed + randomized bench for ss_feeder; expected bursts come from a queue model of frames.
module tb_ss_feeder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        s_valid = 1'b0;
   logic [7:0]  s_data = 8'd0;
   logic        s_ready;
   logic        ss_in_valid;
   logic [15:0] ss_matrix;
   logic        ss_matrix_size;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int nready = 0;

   logic [15:0] obs_w[$];
   bit          obs_s[$];
   int          obs_c[$];
   logic [15:0] exp_w[$];
   bit          exp_s[$];
   int          exp_c[$];
   logic [15:0] pay[$];

   ss_feeder dut (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .ss_in_valid(ss_in_valid), .ss_matrix(ss_matrix), .ss_matrix_size(ss_matrix_size),
      .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n) begin
         if (ss_in_valid) begin
            obs_w.push_back(ss_matrix);
            obs_s.push_back(ss_matrix_size);
            obs_c.push_back(cyc);
         end
         if (!s_ready) nready++;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, o, e);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int bub, output int t);
      int n;
      for (int i = 0; i < bub; i++) begin
         s_valid = 1'b0;
         @(posedge clk); #1;
      end
      s_valid = 1'b1;
      s_data  = b;
      n = 0;
      @(negedge clk);
      while (!s_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!s_ready) begin
         chk("accept_timeout", 32'd0, 32'd1);
         t = -1;
      end else begin
         t = cyc;
      end
      @(posedge clk); #1;
   endtask

   task automatic gen(input bit sz, input bit rnd, input logic [15:0] base);
      pay.delete();
      for (int k = 0; k < (sz ? 32 : 8); k++)
         pay.push_back(rnd ? 16'($urandom) : base + 16'(k));
   endtask

   // Sends header + pay; records the expected burst (words, first-cycle size flag, cycle stamps).
   task automatic send_frame(input logic [7:0] hdr, input int maxbub, input bit keep,
                             output int t_hdr, output int t_last);
      int t;
      send_byte(hdr, (maxbub > 0) ? int'($urandom_range(maxbub, 0)) : 0, t_hdr);
      t_last = 0;
      foreach (pay[i]) begin
         send_byte(pay[i][15:8], (maxbub > 0) ? int'($urandom_range(maxbub, 0)) : 0, t);
         send_byte(pay[i][7:0], (maxbub > 0) ? int'($urandom_range(maxbub, 0)) : 0, t_last);
      end
      if (!keep) s_valid = 1'b0;
      foreach (pay[i]) begin
         exp_w.push_back(pay[i]);
         exp_s.push_back((i == 0) ? hdr[0] : 1'b0);
         exp_c.push_back(t_last + 1 + i);
      end
   endtask

   task automatic check_bursts(input string tag);
      int n;
      chk({tag, "_len"}, obs_w.size(), exp_w.size());
      n = (obs_w.size() < exp_w.size()) ? obs_w.size() : exp_w.size();
      for (int i = 0; i < n; i++) begin
         chk({tag, "_word"}, obs_w[i], exp_w[i]);
         chk({tag, "_size"}, obs_s[i], exp_s[i]);
         chk({tag, "_cycle"}, obs_c[i], exp_c[i]);
      end
      obs_w.delete(); obs_s.delete(); obs_c.delete();
      exp_w.delete(); exp_s.delete(); exp_c.delete();
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int th, tl, th2, tl2;
      logic [7:0] h;
      logic [15:0] w5;

      // reset
      #2 rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_s_ready", s_ready, 1'b0);
         chk("rst_in_valid", ss_in_valid, 1'b0);
         chk("rst_matrix", ss_matrix, 16'd0);
         chk("rst_size", ss_matrix_size, 1'b0);
         chk("rst_busy", busy, 1'b0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_s_ready_0", s_ready, 1'b0);
      @(negedge clk);
      chk("rel_s_ready_1", s_ready, 1'b1);
      chk("rel_busy", busy, 1'b0);
      @(posedge clk); #1;

      // 2x2 continuous
      nready = 0;
      gen(1'b0, 1'b0, 16'h0001);
      send_frame(8'h00, 0, 1'b0, th, tl);
      wait_cycles(8 + 5 + 2);
      check_bursts("f2x2");
      chk("f2x2_ready_low", nready, 13);
      chk("f2x2_ready_back", s_ready, 1'b1);

      // 4x4 with bubbles
      nready = 0;
      gen(1'b1, 1'b0, 16'h1000);
      send_frame(8'h01, 3, 1'b0, th, tl);
      wait_cycles(32 + 11 + 2);
      check_bursts("f4x4");
      chk("f4x4_ready_low", nready, 43);
      chk("f4x4_idle_busy", busy, 1'b0);

      // back-to-back 4x4 then 2x2, s_valid held high
      nready = 0;
      gen(1'b1, 1'b1, 16'h0);
      send_frame(8'h01, 0, 1'b1, th, tl);
      gen(1'b0, 1'b1, 16'h0);
      send_frame(8'h00, 0, 1'b0, th2, tl2);
      chk("b2b_hdr_cycle", th2, tl + 32 + 11 + 1);
      wait_cycles(8 + 5 + 2);
      check_bursts("b2b");
      chk("b2b_ready_low", nready, 32 + 11 + 8 + 5);

      // header 0xFE -> 2x2
      nready = 0;
      gen(1'b0, 1'b1, 16'h0);
      send_frame(8'hFE, 1, 1'b0, th, tl);
      wait_cycles(8 + 5 + 2);
      check_bursts("hfe");
      chk("hfe_ready_low", nready, 13);

      // random frames
      for (int f = 0; f < 4; f++) begin
         h = 8'($urandom);
         nready = 0;
         gen(h[0], 1'b1, 16'h0);
         send_frame(h, 2, 1'b0, th, tl);
         wait_cycles(h[0] ? 32 + 11 + 2 : 8 + 5 + 2);
         check_bursts("rnd");
         chk("rnd_ready_low", nready, h[0] ? 43 : 13);
      end

      // reset mid-PLAY at burst word 5
      gen(1'b0, 1'b1, 16'h0);
      w5 = pay[5];
      send_frame(8'h00, 0, 1'b0, th, tl);
      wait_cycles(5);
      chk("mid_word5_valid", ss_in_valid, 1'b1);
      chk("mid_word5_data", ss_matrix, w5);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", ss_in_valid, 1'b0);
      chk("mid_rst_matrix", ss_matrix, 16'd0);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_ready", s_ready, 1'b0);
      repeat (3) begin
         void'(exp_w.pop_back()); void'(exp_s.pop_back()); void'(exp_c.pop_back());
      end
      check_bursts("mid_partial");
      wait_cycles(2);
      rst_n = 1'b1;
      wait_cycles(2);
      nready = 0;
      gen(1'b0, 1'b1, 16'h0);
      send_frame(8'h00, 1, 1'b0, th, tl);
      wait_cycles(8 + 5 + 2);
      check_bursts("post_rst");
      chk("post_rst_ready_low", nready, 13);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
